// File: rtl/lab3_sched_pkg.sv
// Shared types and default sizes for the round-robin tick scheduler.
package lab3_sched_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned PW_DEF   = 8;
  localparam int unsigned CW_DEF   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } sched_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescale counter: pulses tick one clock after pc reaches psc, then restarts from zero.
module tick_prescaler #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] psc,
  output logic          wrap,
  output logic          tick
);

  logic [PW-1:0] pc_q, pc_d;
  logic          tick_q, tick_d;

  // wrap is the same-cycle terminal-count strobe the scheduler uses to step its tick budget
  assign wrap = en && (pc_q == psc);

  always_comb begin
    pc_d   = pc_q;
    tick_d = 1'b0;
    if (clr) begin
      pc_d = '0;
    end else if (en) begin
      if (wrap) begin
        pc_d   = '0;
        tick_d = 1'b1;
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/lab3_tick_sched.sv
// Round-robin owner of one shared prescaled tick counter; runs one delay job at a time.
module lab3_tick_sched
  import lab3_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned PW   = PW_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*PW-1:0] psc_in,
  input  logic [NREQ*CW-1:0] cnt_in,
  input  logic               abort,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               tick,
  output logic               busy
);

  localparam int unsigned IW = $clog2(NREQ);

  sched_state_t    state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d, pick_oh;
  logic [IW-1:0]   owner_q, owner_d, last_q, last_d, pick_idx, cand;
  logic [PW-1:0]   psc_q, psc_d, psc_sel;
  logic [CW-1:0]   rem_q, rem_d, cnt_sel;
  logic            busy_q, pick_vld, pre_clr, pre_en, pre_wrap;

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(last_q) + i) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_oh = NREQ'(1) << pick_idx;

  always_comb begin
    psc_sel = '0;
    cnt_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        psc_sel = psc_in[i*PW +: PW];
        cnt_sel = cnt_in[i*CW +: CW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    owner_d = owner_q;
    last_d  = last_q;
    psc_d   = psc_q;
    rem_d   = rem_q;
    pre_clr = 1'b0;
    pre_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d = pick_oh;
          owner_d = pick_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        pre_clr = 1'b1;
        if (abort) begin
          grant_d = '0;
          last_d  = owner_q;
          state_d = StIdle;
        end else begin
          psc_d = psc_sel;
          rem_d = cnt_sel;
          if (cnt_sel == '0) begin
            done_d  = grant_q;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          // Abort beats a coinciding final tick: no tick, no done.
          pre_clr = 1'b1;
          grant_d = '0;
          last_d  = owner_q;
          state_d = StIdle;
        end else begin
          pre_en = 1'b1;
          if (pre_wrap) begin
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              done_d  = grant_q;
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        grant_d = '0;
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      psc_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      psc_q   <= psc_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  tick_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .psc   (psc_q),
    .wrap  (pre_wrap),
    .tick  (tick)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_lab3_tick_sched.sv
// Scoreboard bench: expected grant/tick/done events are queued at stimulus time.
module tb_lab3_tick_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*8-1:0] psc_in;
  logic [N*8-1:0] cnt_in;
  logic           abort;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           tick;
  logic           busy;

  typedef struct {
    int         e;
    logic [N-1:0] v;
  } ev_t;

  ev_t          grant_q[$];
  ev_t          done_q[$];
  int           tick_q[$];
  int           edge_n    = 0;
  int           n_checks  = 0;
  int           n_pass    = 0;
  int           exp_last  = N - 1;
  logic [N-1:0] prev_grant = '0;

  lab3_tick_sched #(
    .NREQ (N),
    .PW   (8),
    .CW   (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .psc_in (psc_in),
    .cnt_in (cnt_in),
    .abort  (abort),
    .grant  (grant),
    .done   (done),
    .tick   (tick),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, got, exp, edge_n);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      int c = (last + i) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic push_job(input int e0, input int owner, input int p, input int c,
                          input int abort_edge);
    ev_t ev;
    ev.e = e0;
    ev.v = N'(1) << owner;
    grant_q.push_back(ev);
    for (int k = 1; k <= c; k++) begin
      int te = e0 + 1 + k * (p + 1);
      if (abort_edge == 0 || te < abort_edge) tick_q.push_back(te);
    end
    if (abort_edge == 0) begin
      ev.e = (c == 0) ? e0 + 1 : e0 + 1 + c * (p + 1);
      done_q.push_back(ev);
    end
  endtask

  // Job granted at edge e0 from the current req; abort_edge 0 means it runs to completion.
  task automatic sched(input int e0, input int abort_edge);
    int o = rr_pick(req, exp_last);
    if (o >= 0) begin
      push_job(e0, o, int'(psc_in[o*8 +: 8]), int'(cnt_in[o*8 +: 8]), abort_edge);
      exp_last = o;
    end
  endtask

  task automatic set_cfg(input int i, input int p, input int c);
    psc_in[i*8 +: 8] = 8'(p);
    cnt_in[i*8 +: 8] = 8'(c);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 32'(busy), 0);
  endtask

  initial forever begin
    ev_t ev;
    @(negedge clk);
    if (grant != '0 && prev_grant == '0) begin
      if (grant_q.size() == 0) check("grant_unexp", 32'(grant), 0);
      else begin
        ev = grant_q.pop_front();
        check("grant_val", 32'(grant), 32'(ev.v));
        check("grant_edge", edge_n, ev.e);
      end
    end
    prev_grant = grant;
    if (tick) begin
      if (tick_q.size() == 0) check("tick_unexp", 32'(tick), 0);
      else check("tick_edge", edge_n, tick_q.pop_front());
    end
    if (done != '0) begin
      if (done_q.size() == 0) check("done_unexp", 32'(done), 0);
      else begin
        ev = done_q.pop_front();
        check("done_val", 32'(done), 32'(ev.v));
        check("done_edge", edge_n, ev.e);
      end
    end
  end

  initial begin
    int e0, e1;
    reset  = 1'b1;
    req    = '0;
    abort  = 1'b0;
    psc_in = '0;
    cnt_in = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single job, P=3 C=2.
    set_cfg(0, 3, 2);
    req = 4'b0001;
    e0  = edge_n + 1;
    sched(e0, 0);
    wait_edge(e0);
    req = '0;
    wait_edge(e0 + 9);
    check("t1_busy_at_done", 32'(busy), 1);
    check("t1_done", 32'(done), 32'h1);
    wait_edge(e0 + 10);
    check("t1_idle", 32'(busy), 0);
    check("t1_grant_clr", 32'(grant), 0);

    // Zero count, P=7: done straight out of LOAD, no tick.
    set_cfg(0, 7, 0);
    req = 4'b0001;
    e0  = edge_n + 1;
    sched(e0, 0);
    wait_edge(e0);
    req = '0;
    wait_edge(e0 + 2);
    check("t2_idle", 32'(busy), 0);

    // Round-robin with all requesters held, P=0 C=1.
    for (int i = 0; i < N; i++) set_cfg(i, 0, 1);
    req = 4'b1111;
    e0  = edge_n + 1;
    for (int j = 0; j < 5; j++) sched(e0 + 4 * j, 0);
    wait_edge(e0 + 16);
    req = '0;
    wait_edge(e0 + 19);
    check("t3_idle", 32'(busy), 0);

    // Abort mid-run; the other requester then completes.
    set_cfg(0, 1, 10);
    set_cfg(1, 1, 10);
    req = 4'b0011;
    e0  = edge_n + 1;
    sched(e0, e0 + 6);
    e1 = e0 + 7;
    sched(e1, 0);
    wait_edge(e0 + 5);
    abort = 1'b1;
    wait_edge(e0 + 6);
    abort = 1'b0;
    check("t4_abort_grant", 32'(grant), 0);
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_done", 32'(done), 0);
    wait_edge(e1);
    req = '0;
    wait_edge(e1 + 22);
    check("t4_idle", 32'(busy), 0);

    // Abort coinciding with the final tick.
    set_cfg(2, 0, 3);
    req = 4'b0100;
    e0  = edge_n + 1;
    sched(e0, e0 + 4);
    wait_edge(e0);
    req = '0;
    wait_edge(e0 + 3);
    abort = 1'b1;
    wait_edge(e0 + 4);
    abort = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0);
    check("t5_tick", 32'(tick), 0);
    wait_edge(e0 + 7);

    // Asynchronous reset during the second job's RUN.
    set_cfg(0, 3, 5);
    set_cfg(1, 3, 5);
    req = 4'b0011;
    e0  = edge_n + 1;
    sched(e0, 0);
    e1 = e0 + 23;
    sched(e1, 0);
    wait_edge(e1 + 4);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_tick", 32'(tick), 0);
    check("t6_rst_busy", 32'(busy), 0);
    grant_q.delete();
    tick_q.delete();
    done_q.delete();
    exp_last = N - 1;
    req = 4'b0110;
    set_cfg(1, 0, 2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    e0 = edge_n + 1;
    sched(e0, 0);
    wait_edge(e0);
    req = '0;
    wait_idle(50);

    repeat (3) @(negedge clk);
    check("grant_q_drained", grant_q.size(), 0);
    check("tick_q_drained", tick_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
